arb4_rr_ctrl: RTL and testbench

ARB4_RR_CTRL -- requirements
Module: arb4_rr_ctrl

---
 rtl/arb4_rr_ctrl.sv | 138 +++++++++++++
 tb/tb_arb4_rr_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb4_rr_ctrl.sv
// Four-requester arbiter with round-robin or fixed priority, a per-owner
// hold limit, and a mandatory one-cycle idle gap between owners.
module arb4_rr_ctrl #(
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  ptr_r, ptr_nxt_s;
  logic [7:0]  hold_r, hold_nxt_s;
  logic [3:0]  rot_s;
  logic [1:0]  rr_off_s, rr_win_s, fix_win_s, win_s;
  logic        rel_exit_s, drop_exit_s, limit_exit_s, exit_s;
  logic [3:0]  gnt_nxt_s;
  logic [1:0]  gnt_id_nxt_s;
  logic        busy_nxt_s, timeout_nxt_s;

  // Winner selection: rotate req so the pointer position lands at bit 0
  always_comb begin
    rot_s = req;
    case (ptr_r)
      2'd0:    rot_s = req;
      2'd1:    rot_s = {req[0],   req[3:1]};
      2'd2:    rot_s = {req[1:0], req[3:2]};
      2'd3:    rot_s = {req[2:0], req[3]};
      default: rot_s = req;
    endcase
    rr_off_s = 2'd0;
    casez (rot_s)
      4'b???1: rr_off_s = 2'd0;
      4'b??10: rr_off_s = 2'd1;
      4'b?100: rr_off_s = 2'd2;
      4'b1000: rr_off_s = 2'd3;
      default: rr_off_s = 2'd0;
    endcase
    fix_win_s = 2'd0;
    casez (req)
      4'b1???: fix_win_s = 2'd3;
      4'b01??: fix_win_s = 2'd2;
      4'b001?: fix_win_s = 2'd1;
      default: fix_win_s = 2'd0;
    endcase
    rr_win_s = ptr_r + rr_off_s;
    win_s    = (RR_MODE != 0) ? rr_win_s : fix_win_s;
  end

  // Exit causes out of GRANT; the limit alone is what raises timeout
  always_comb begin
    rel_exit_s   = rel;
    drop_exit_s  = ~req[gnt_id];
    limit_exit_s = (hold_r == 8'(MAX_HOLD));
    exit_s       = rel_exit_s | drop_exit_s | limit_exit_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) state_nxt_s = GRANT;
        else                state_nxt_s = IDLE;
      end
      GRANT: begin
        if (exit_s) state_nxt_s = IDLE;
        else        state_nxt_s = GRANT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    gnt_nxt_s     = 4'b0000;
    gnt_id_nxt_s  = gnt_id;
    busy_nxt_s    = 1'b0;
    timeout_nxt_s = 1'b0;
    ptr_nxt_s     = ptr_r;
    hold_nxt_s    = hold_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          gnt_nxt_s    = 4'b0001 << win_s;
          gnt_id_nxt_s = win_s;
          busy_nxt_s   = 1'b1;
          hold_nxt_s   = 8'd1;
          ptr_nxt_s    = win_s + 2'd1;
        end else begin
          gnt_nxt_s    = 4'b0000;
        end
      end
      GRANT: begin
        if (exit_s) begin
          timeout_nxt_s = limit_exit_s & ~rel_exit_s & ~drop_exit_s;
        end else begin
          gnt_nxt_s  = gnt;
          busy_nxt_s = 1'b1;
          hold_nxt_s = (hold_r == 8'hFF) ? hold_r : hold_r + 8'd1;
        end
      end
      default: begin
        gnt_nxt_s = 4'b0000;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      hold_r  <= 8'd0;
      gnt     <= 4'b0000;
      gnt_id  <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      hold_r  <= hold_nxt_s;
      gnt     <= gnt_nxt_s;
      gnt_id  <= gnt_id_nxt_s;
      busy    <= busy_nxt_s;
      timeout <= timeout_nxt_s;
    end
  end

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Self-checking bench: a round-robin (MAX_HOLD=4) and a fixed-priority
// (MAX_HOLD=3) instance share stimulus and are compared to a reference model.
module tb_arb4_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;

  logic [3:0] rr_gnt, fx_gnt;
  logic [1:0] rr_gnt_id, fx_gnt_id;
  logic       rr_busy, fx_busy, rr_timeout, fx_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  arb4_rr_ctrl #(.RR_MODE(1), .MAX_HOLD(4)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .gnt(rr_gnt), .gnt_id(rr_gnt_id), .busy(rr_busy), .timeout(rr_timeout)
  );

  arb4_rr_ctrl #(.RR_MODE(0), .MAX_HOLD(3)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .gnt(fx_gnt), .gnt_id(fx_gnt_id), .busy(fx_busy), .timeout(fx_timeout)
  );

  typedef struct {
    int owner;   // -1 when nobody holds the grant
    int cnt;
    int ptr;
    int id;
    bit to;
  } model_t;

  model_t m_rr, m_fx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic model_t reset_model();
    model_t r;
    r.owner = -1; r.cnt = 0; r.ptr = 0; r.id = 0; r.to = 1'b0;
    return r;
  endfunction

  // One clock of arbitration rules applied to the sampled req/rel
  function automatic model_t step_fn(model_t s, bit rr, int maxh, logic [3:0] r, logic l);
    model_t n;
    int w, c;
    bit lim, drop;
    n = s;
    n.to = 1'b0;
    w = -1;
    if (s.owner < 0) begin
      if (r != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (rr) begin
            c = (s.ptr + k) % 4;
            if (w < 0 && r[c]) w = c;
          end else if (r[k]) begin
            w = k;
          end
        end
        n.owner = w; n.id = w; n.cnt = 1; n.ptr = (w + 1) % 4;
      end
    end else begin
      lim  = (s.cnt == maxh);
      drop = !r[s.owner];
      if (l || drop || lim) begin
        n.to = lim && !l && !drop;
        n.owner = -1;
      end else begin
        n.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_gnt(model_t s);
    return (s.owner >= 0) ? 4'(1 << s.owner) : 4'b0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr <= reset_model();
      m_fx <= reset_model();
    end else begin
      m_rr <= step_fn(m_rr, 1'b1, 4, req, rel);
      m_fx <= step_fn(m_fx, 1'b0, 3, req, rel);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("rr_gnt",     32'(rr_gnt),     32'(exp_gnt(m_rr)));
      check_eq("rr_gnt_id",  32'(rr_gnt_id),  32'(m_rr.id));
      check_eq("rr_busy",    32'(rr_busy),    32'(m_rr.owner >= 0));
      check_eq("rr_timeout", 32'(rr_timeout), 32'(m_rr.to));
      check_eq("fx_gnt",     32'(fx_gnt),     32'(exp_gnt(m_fx)));
      check_eq("fx_gnt_id",  32'(fx_gnt_id),  32'(m_fx.id));
      check_eq("fx_busy",    32'(fx_busy),    32'(m_fx.owner >= 0));
      check_eq("fx_timeout", 32'(fx_timeout), 32'(m_fx.to));
    end
  end

  task automatic wait_rr_busy(input logic want, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (rr_busy === want) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_eq("wait_bound", 32'(rr_busy), 32'(want));
  endtask

  int exp_seq[5] = '{0, 1, 2, 3, 0};
  int n_hold;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_gnt",     32'(rr_gnt | fx_gnt), 32'h0);
    check_eq("rst_gnt_id",  32'(rr_gnt_id),       32'h0);
    check_eq("rst_busy",    32'(rr_busy),         32'h0);
    check_eq("rst_timeout", 32'(rr_timeout),      32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // All requesting, rel after two GRANT cycles
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_rr_busy(1'b1, 4);
      check_eq("rr_seq", 32'(rr_gnt_id), 32'(exp_seq[g]));
      check_eq("fx_id3", 32'(fx_gnt_id), 32'd3);
      @(negedge clk);
      rel = 1'b1;
      @(negedge clk);
      rel = 1'b0;
      check_eq("rr_gap", 32'(rr_busy), 32'h0);
      check_eq("fx_gap", 32'(fx_busy), 32'h0);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Hold limit on a single requester
    req = 4'b0100;
    wait_rr_busy(1'b1, 4);
    n_hold = 0;
    while (rr_busy && n_hold < 10) begin
      n_hold++;
      @(negedge clk);
    end
    check_eq("rr_hold_len", 32'(n_hold),     32'd4);
    check_eq("rr_to_pulse", 32'(rr_timeout), 32'h1);
    check_eq("rr_to_gap",   32'(rr_gnt),     32'h0);
    @(negedge clk);
    check_eq("rr_regrant",  32'(rr_gnt),     32'h4);
    check_eq("rr_to_once",  32'(rr_timeout), 32'h0);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Owner 1 drops while requester 3 rises
    req = 4'b0010;
    wait_rr_busy(1'b1, 4);
    check_eq("rr_own1", 32'(rr_gnt_id), 32'd1);
    req = 4'b1000;
    @(negedge clk);
    check_eq("drop_idle", 32'(rr_busy),    32'h0);
    check_eq("drop_to",   32'(rr_timeout), 32'h0);
    @(negedge clk);
    check_eq("drop_gnt3", 32'(rr_gnt),     32'h8);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // rel coincides with the hold limit
    req = 4'b0100;
    wait_rr_busy(1'b1, 4);
    repeat (3) @(negedge clk);
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
    check_eq("rel_lim_busy", 32'(rr_busy),    32'h0);
    check_eq("rel_lim_to",   32'(rr_timeout), 32'h0);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-GRANT, then pointer restarts at 0
    req = 4'b1111;
    @(negedge clk);
    wait_rr_busy(1'b1, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rr_gnt", 32'(rr_gnt),  32'h0);
    check_eq("async_fx_gnt", 32'(fx_gnt),  32'h0);
    check_eq("async_busy",   32'(rr_busy), 32'h0);
    @(negedge clk);
    req = 4'b1010;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rr", 32'(rr_gnt),    32'h2);
    check_eq("post_rst_fx", 32'(fx_gnt_id), 32'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) req = 4'($urandom);
      rel = ($urandom_range(5) == 0);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
